// File: rtl/qdrc_pkg.sv
// Shared QDR controller definitions: default widths, returned-word type, clog2.
package qdrc_pkg;

  localparam int QDRC_DATA_WIDTH = 36;
  localparam int QDRC_ADDR_WIDTH = 21;
  localparam int QDRC_TAG_WIDTH  = 8;

  // One returned read word is two QDR beats.
  typedef logic [2*QDRC_DATA_WIDTH-1:0] qdrc_word_t;

  // Ceiling log2, usable in parameter expressions (bounded loop for synthesis).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/qdrc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered memory.
// DEPTH must be a power of two so pointers wrap naturally.
module qdrc_sync_fifo import qdrc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Head is visible as soon as it is written; driven 0 when empty.
  assign dout = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only read when counted valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qdrc_rd_buf.sv
// QDR read request/return buffer. Tags are queued at accept, returned words
// at rd_dvld; both pop together on the output handshake. The tag FIFO depth
// is the credit pool, so every return has a data slot waiting for it.
// Optional: define QDRC_RD_BUF_STATUS_EN for err_unsolicited and occupancy.
module qdrc_rd_buf import qdrc_pkg::*; #(
  parameter int DATA_WIDTH = QDRC_DATA_WIDTH,
  parameter int ADDR_WIDTH = QDRC_ADDR_WIDTH,
  parameter int TAG_WIDTH  = QDRC_TAG_WIDTH,
  parameter int DEPTH      = 16,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    phy_rdy,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [TAG_WIDTH-1:0]    req_tag,
  output logic                    rd_strb,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [2*DATA_WIDTH-1:0] rd_data,
  input  logic                    rd_dvld,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]    out_tag
`ifdef QDRC_RD_BUF_STATUS_EN
  ,
  output logic                    err_unsolicited,
  output logic [AW:0]             occupancy
`endif
);

  logic [AW:0]             tag_cnt, data_cnt;
  logic                    tag_full, tag_empty, data_full, data_empty;
  logic [TAG_WIDTH-1:0]    tag_head;
  logic [2*DATA_WIDTH-1:0] data_head;
  logic                    accept, pop, unsol, data_push;

  // Credit check: a free tag slot also reserves the matching data slot.
  assign req_ready = phy_rdy && !tag_full && !reset;
  assign accept    = req_valid && req_ready;
  assign rd_strb   = accept;
  assign rd_addr   = accept ? req_addr : '0;

  assign out_valid = !data_empty;
  assign pop       = out_valid && out_ready && !tag_empty;
  assign out_data  = data_head;
  assign out_tag   = out_valid ? tag_head : '0;

  // A return with no outstanding read has no tag to pair with: drop it.
  assign unsol     = rd_dvld && (data_cnt == tag_cnt);
  assign data_push = rd_dvld && !unsol && !data_full;

  qdrc_sync_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (req_tag),
    .pop   (pop),
    .dout  (tag_head),
    .count (tag_cnt),
    .full  (tag_full),
    .empty (tag_empty)
  );

  qdrc_sync_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_push),
    .din   (rd_data),
    .pop   (pop),
    .dout  (data_head),
    .count (data_cnt),
    .full  (data_full),
    .empty (data_empty)
  );

`ifdef QDRC_RD_BUF_STATUS_EN
  assign occupancy = tag_cnt;

  // Sticky flag for returns that arrived with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)      err_unsolicited <= 1'b0;
    else if (unsol) err_unsolicited <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_qdrc_rd_buf.sv
// Scoreboard bench for qdrc_rd_buf: the stimulus process acts as the QDR
// read path and pushes the expected (tag, word) pair whenever it returns data;
// a monitor pops and compares on every output handshake.
module tb_qdrc_rd_buf;
  import qdrc_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = clog2(DEPTH);

  logic                 clk = 1'b0;
  logic                 reset, phy_rdy, req_valid, req_ready;
  logic [20:0]          req_addr, rd_addr;
  logic [7:0]           req_tag, out_tag;
  logic                 rd_strb, rd_dvld, out_valid, out_ready;
  qdrc_word_t           rd_data, out_data;
`ifdef QDRC_RD_BUF_STATUS_EN
  logic                 err_unsolicited;
  logic [AW:0]          occupancy;
`endif

  typedef struct packed {
    logic [7:0] tag;
    qdrc_word_t data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  qdrc_rd_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .phy_rdy   (phy_rdy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_tag   (req_tag),
    .rd_strb   (rd_strb),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_dvld   (rd_dvld),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef QDRC_RD_BUF_STATUS_EN
    ,
    .err_unsolicited (err_unsolicited),
    .occupancy       (occupancy)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [7:0] tag, input qdrc_word_t data);
    exp_t e;
    rd_dvld = 1'b1;
    rd_data = data;
    e.tag   = tag;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: compare every handshake against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_tag", {120'd0, out_tag}, 128'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_tag",  {120'd0, out_tag}, {120'd0, e.tag});
        check("out_data", {56'd0, out_data}, {56'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    qdrc_word_t dv [4];
    int acc;
    dv[0] = 72'hD0_1111_2222_3333_4444;
    dv[1] = 72'hD1_5555_6666_7777_8888;
    dv[2] = 72'hD2_9999_AAAA_BBBB_CCCC;
    dv[3] = 72'hD3_DDDD_EEEE_FFFF_0000;

    reset = 1'b1; phy_rdy = 1'b1; req_valid = 1'b0; req_addr = '0; req_tag = '0;
    rd_dvld = 1'b0; rd_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_rd_strb",   128'(rd_strb),   128'd0);

    // Gate on phy_rdy, then accept with a same-cycle strobe.
    phy_rdy = 1'b0; reset = 1'b0; tick();
    req_valid = 1'b1; req_addr = 21'h1ABCD; req_tag = 8'h0A; #1;
    check("nophy_req_ready", 128'(req_ready), 128'd0);
    check("nophy_rd_strb",   128'(rd_strb),   128'd0);
    tick();
    phy_rdy = 1'b1; #1;
    check("phy_req_ready", 128'(req_ready), 128'd1);
    check("phy_rd_strb",   128'(rd_strb),   128'd1);
    check("phy_rd_addr",   128'(rd_addr),   128'h1ABCD);
    tick();
    req_valid = 1'b0;
    tick();
    ret(8'h0A, 72'hA5); tick(); rd_dvld = 1'b0;
    out_ready = 1'b1;
    drain("t1_drain");

    // Four tagged reads, fixed-latency in-order returns.
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_tag = 8'h11 + 8'(i); req_addr = 21'(i); #1;
      check("t2_rd_strb", 128'(rd_strb), 128'd1);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 4; i++) begin
      ret(8'h11 + 8'(i), dv[i]);
      if (i == 0) begin #1; check("t2_pre_valid", 128'(out_valid), 128'd0); end
      tick();
      if (i == 0) check("t2_post_valid", 128'(out_valid), 128'd1);
    end
    rd_dvld = 1'b0;
    drain("t2_drain");

    // Fill the credit pool with the consumer stalled.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1; req_tag = 8'h20 + 8'(i); req_addr = 21'(i); #1;
      if (req_ready) acc++;
      if (i == 16) check("full_req_ready", 128'(req_ready), 128'd0);
      tick();
    end
    req_valid = 1'b0;
    check("accepted_count", 128'(acc), 128'd16);
    // Returns keep arriving while the head is held.
    for (int j = 0; j < 16; j++) begin
      ret(8'h20 + 8'(j), qdrc_word_t'(72'h100 + j));
      if (j >= 1 && j <= 5) begin
        check("hold_tag",  {120'd0, out_tag},  128'h20);
        check("hold_data", {56'd0, out_data},  128'h100);
      end
      tick();
    end
    rd_dvld = 1'b0;
    out_ready = 1'b1; #1;
    check("credit_before_pop", 128'(req_ready), 128'd0);
    tick();
    out_ready = 1'b0; #1;
    check("credit_release", 128'(req_ready), 128'd1);
    req_valid = 1'b1; req_tag = 8'h30; req_addr = 21'h30; #1;
    check("t3_17th_strb", 128'(rd_strb), 128'd1);
    tick();
    req_valid = 1'b0; #1;
    check("refull_req_ready", 128'(req_ready), 128'd0);
    ret(8'h30, 72'h130); tick(); rd_dvld = 1'b0;
    out_ready = 1'b1;
    drain("t3_drain");

    // Unsolicited return with nothing outstanding.
`ifdef QDRC_RD_BUF_STATUS_EN
    check("err_before", 128'(err_unsolicited), 128'd0);
`endif
    rd_dvld = 1'b1; rd_data = 72'hBAD; tick(); rd_dvld = 1'b0;
    check("unsol_out_valid", 128'(out_valid), 128'd0);
`ifdef QDRC_RD_BUF_STATUS_EN
    check("err_set", 128'(err_unsolicited), 128'd1);
    tick(); tick();
    check("err_sticky", 128'(err_unsolicited), 128'd1);
    check("occ_idle",   128'(occupancy),       128'd0);
`endif

    // Reset with 3 in flight and 2 buffered; nothing may survive it.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_tag = 8'h40 + 8'(i); tick();
    end
    req_valid = 1'b0;
    rd_dvld = 1'b1; rd_data = 72'h400; tick();
    rd_data = 72'h401; tick(); rd_dvld = 1'b0;
`ifdef QDRC_RD_BUF_STATUS_EN
    check("occ_before_rst", 128'(occupancy), 128'd5);
`endif
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("post_rst_valid", 128'(out_valid), 128'd0);
    check("post_rst_ready", 128'(req_ready), 128'd1);
`ifdef QDRC_RD_BUF_STATUS_EN
    check("post_rst_occ", 128'(occupancy),       128'd0);
    check("post_rst_err", 128'(err_unsolicited), 128'd0);
`endif
    req_valid = 1'b1; req_tag = 8'h55; req_addr = 21'h55; tick();
    req_valid = 1'b0; tick(); tick();
    ret(8'h55, 72'h555); tick(); rd_dvld = 1'b0;
    out_ready = 1'b1;
    drain("t6_drain");
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
